// File: rtl/feedback_diff.sv
// Stream differentiator: recovers sum[n]-sum[n-1] from a running-sum stream behind a 2-entry output FIFO.
// Optional build macro FBDIFF_CLAMP_EN clamps signed deltas to +/-MAX_STEP and raises sticky err_step.
module feedback_diff #(
    parameter int WIDTH    = 16,
    parameter int MAX_STEP = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             sum_valid,
    output logic             sum_ready,
    input  logic             resync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             primed,
    output logic             err_step
);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] prev_r;
    logic [WIDTH-1:0] buf0_r;
    logic [WIDTH-1:0] buf1_r;
    logic [1:0]       count_r;
    logic             valid_r;
    logic             primed_r;
    logic             err_r;

    logic             push_s;
    logic             pop_s;
    logic [1:0]       count_nxt_s;
    logic [WIDTH-1:0] raw_delta_s;
    logic [WIDTH-1:0] data_s;
    logic             over_s;

`ifdef FBDIFF_CLAMP_EN
    localparam logic signed [WIDTH-1:0] MAX_POS = WIDTH'(MAX_STEP);
    localparam logic signed [WIDTH-1:0] MAX_NEG = -MAX_POS;

    // Returns {out_of_range, clamped_value} for a two's-complement delta.
    function automatic logic [WIDTH:0] clamp_step(input logic [WIDTH-1:0] d);
        logic signed [WIDTH-1:0] sd;
        sd = d;
        if (sd > MAX_POS) begin
            clamp_step = {1'b1, MAX_POS};
        end else if (sd < MAX_NEG) begin
            clamp_step = {1'b1, MAX_NEG};
        end else begin
            clamp_step = {1'b0, d};
        end
    endfunction
`endif

    assign push_s      = sum_valid && sum_ready;
    assign pop_s       = valid_r && dout_ready;
    assign raw_delta_s = sum_in - prev_r;

    // Ready: room in the buffer, or a full buffer that is popping this cycle.
    always_comb begin
        sum_ready = 1'b0;
        if (rst) begin
            sum_ready = 1'b0;
        end else if (count_r < 2'd2) begin
            sum_ready = 1'b1;
        end else begin
            sum_ready = dout_ready;
        end
    end

    // Delta to enqueue; the first sample after priming passes through unchecked.
    always_comb begin
        data_s = raw_delta_s;
        over_s = 1'b0;
        if (state_r == ST_PRIME) begin
            data_s = sum_in;
        end else begin
`ifdef FBDIFF_CLAMP_EN
            {over_s, data_s} = clamp_step(raw_delta_s);
`else
            data_s = raw_delta_s;
`endif
        end
    end

    // Next buffer occupancy.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // FSM, previous-sum register, output FIFO and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_PRIME;
            prev_r   <= {WIDTH{1'b0}};
            buf0_r   <= {WIDTH{1'b0}};
            buf1_r   <= {WIDTH{1'b0}};
            count_r  <= 2'd0;
            valid_r  <= 1'b0;
            primed_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        buf0_r <= data_s;
                    end else begin
                        buf1_r <= data_s;
                    end
                end
                2'b01: begin
                    buf0_r <= buf1_r;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        buf0_r <= data_s;
                    end else begin
                        buf0_r <= buf1_r;
                        buf1_r <= data_s;
                    end
                end
                default: begin
                end
            endcase
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);

            // resync wins over the state update of a coincident accept
            if (resync) begin
                state_r  <= ST_PRIME;
                prev_r   <= {WIDTH{1'b0}};
                primed_r <= 1'b0;
            end else if (push_s) begin
                state_r  <= ST_RUN;
                prev_r   <= sum_in;
                primed_r <= 1'b1;
            end else begin
                state_r  <= state_r;
                prev_r   <= prev_r;
                primed_r <= primed_r;
            end

            if (push_s && over_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign dout       = buf0_r;
    assign dout_valid = valid_r;
    assign primed     = primed_r;
`ifdef FBDIFF_CLAMP_EN
    assign err_step   = err_r;
`else
    assign err_step   = 1'b0;
`endif

endmodule

// File: tb/tb_feedback_diff.sv
// Scoreboard bench for feedback_diff: reference model queues expected deltas, a monitor checks outputs.
module tb_feedback_diff;
    localparam int W  = 16;
    localparam int MS = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sum_in = '0;
    logic         sum_valid = 1'b0;
    logic         sum_ready;
    logic         resync = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic         primed;
    logic         err_step;

    int checks = 0;
    int errors = 0;
    bit rnd_mode = 1'b0;

    // reference model state
    int m_prev   = 0;
    bit m_primed = 1'b0;
    bit m_err    = 1'b0;
    int exp_q[$];

    feedback_diff #(.WIDTH(W), .MAX_STEP(MS)) dut (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sum_ready),
        .resync(resync), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .primed(primed), .err_step(err_step)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input int s);
        int d;
        if (!m_primed) begin
            d = s;
        end else begin
            d = s - m_prev;
            if (d > 32767) d -= 65536;
            if (d < -32768) d += 65536;
`ifdef FBDIFF_CLAMP_EN
            if (d > MS) begin d = MS; m_err = 1'b1; end
            if (d < -MS) begin d = -MS; m_err = 1'b1; end
`endif
        end
        exp_q.push_back(d & 32'hFFFF);
        m_prev = s;
        m_primed = 1'b1;
    endtask

    task automatic rand_ready();
        if (rnd_mode) dout_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int s, input bit rs);
        int tries;
        bit first;
        tries = 0;
        first = 1'b1;
        sum_in = s[W-1:0];
        sum_valid = 1'b1;
        resync = rs;
        rand_ready();
        forever begin
            @(negedge clk);
            if (sum_ready) begin
                model_accept(s);
                if (first && rs) begin m_prev = 0; m_primed = 1'b0; end
                break;
            end
            if (first && rs) begin m_prev = 0; m_primed = 1'b0; end
            first = 1'b0;
            tries++;
            if (tries > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
            resync = 1'b0;
            rand_ready();
        end
        @(posedge clk); #1;
        sum_valid = 1'b0;
        resync = 1'b0;
    endtask

    task automatic idle(input int n);
        sum_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            rand_ready();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sum_valid = 1'b0;
        resync = 1'b0;
        exp_q.delete();
        m_prev = 0; m_primed = 1'b0; m_err = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_dout", int'(dout), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_primed", int'(primed), 0);
        check("rst_err_step", int'(err_step), 0);
        check("rst_sum_ready", int'(sum_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        dout_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        logic [W-1:0] last_dout;
        bit stalled;
        int e;
        stalled = 1'b0;
        last_dout = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_valid", int'(dout_valid), 1);
                    check("stall_dout", int'(dout), int'(last_dout));
                end
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_dout", int'(dout), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("dout", int'(dout), e);
                    end
                end
                stalled = dout_valid && !dout_ready;
                last_dout = dout;
            end
        end
    end

    initial begin
        int s;
        do_reset();

        // basic sequence with latency and primed checks
        dout_ready = 1'b1;
        send(20, 1'b0);
        check("latency_valid", int'(dout_valid), 1);
        check("primed_rise", int'(primed), 1);
        send(25, 1'b0);
        send(29, 1'b0);
        send(32, 1'b0);
        idle(2);
        check("basic_drained", exp_q.size(), 0);

        // wrap-around
        do_reset();
        send(16'hFFF0, 1'b0);
        send(16'h0005, 1'b0);
        idle(2);
        check("wrap_drained", exp_q.size(), 0);

        // backpressure
        do_reset();
        dout_ready = 1'b0;
        send(10, 1'b0);
        send(17, 1'b0);
        sum_in = 16'd30;
        sum_valid = 1'b1;
        @(negedge clk);
        check("full_sum_ready", int'(sum_ready), 0);
        check("full_head", int'(dout), 10);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_sum_ready2", int'(sum_ready), 0);
        @(posedge clk); #1;
        dout_ready = 1'b1;
        send(30, 1'b0);
        idle(3);
        check("bp_drained", exp_q.size(), 0);

        // resync, standalone and coincident with an accept
        do_reset();
        send(20, 1'b0);
        send(25, 1'b0);
        resync = 1'b1;
        @(negedge clk);
        m_prev = 0; m_primed = 1'b0;
        @(posedge clk); #1;
        resync = 1'b0;
        check("resync_primed_fall", int'(primed), 0);
        send(8, 1'b0);
        send(25, 1'b0);
        send(40, 1'b1);
        check("resync_coincident_primed", int'(primed), 0);
        send(50, 1'b0);
        idle(2);
        check("resync_drained", exp_q.size(), 0);

        // reset with two entries buffered
        dout_ready = 1'b0;
        send(5, 1'b0);
        send(6, 1'b0);
        do_reset();
        dout_ready = 1'b1;
        send(9, 1'b0);
        idle(2);
        check("midrst_drained", exp_q.size(), 0);

`ifdef FBDIFF_CLAMP_EN
        do_reset();
        send(100, 1'b0);
        send(1000, 1'b0);
        send(0, 1'b0);
        idle(2);
        check("clamp_err", int'(err_step), 1);
        check("clamp_drained", exp_q.size(), 0);
`endif

        // randomized traffic
        do_reset();
        rnd_mode = 1'b1;
        s = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            if ($urandom_range(0, 3) == 0) s = int'($urandom_range(0, 65535));
            else s = (s + int'($urandom_range(0, 600)) - 300) & 32'hFFFF;
            send(s, ($urandom_range(0, 15) == 0));
        end
        rnd_mode = 1'b0;
        drain("rand_drained");
        check("rand_err_step", int'(err_step), int'(m_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/feedback_diff.md
# feedback_diff

Stream differentiator that inverts the feedback adder. It accepts the adder's running-sum stream and recovers each per-sample increment as `sum[n] - sum[n-1]` modulo 2^WIDTH. It sits downstream of `feedback` and is used for loopback checking and for rebuilding the original `din` sequence. Both sides use valid/ready handshakes, and a 2-entry output buffer absorbs backpressure.

## Interface
- `WIDTH`, 16, sample width in bits.
- `MAX_STEP`, 255, largest legal signed increment magnitude; used only with `FBDIFF_CLAMP_EN`.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `sum_in`  in  WIDTH  running-sum sample.
- `sum_valid`  in  1  `sum_in` is valid.
- `sum_ready`  out  1  the block can accept `sum_in`.
- `resync`  in  1  single-cycle pulse that re-primes the block, so the next sample is taken as relative to 0.
- `dout`  out  WIDTH  recovered increment.
- `dout_valid`  out  1  `dout` is valid.
- `dout_ready`  in  1  downstream accepts `dout`.
- `primed`  out  1  a previous sum is held (state RUN).
- `err_step`  out  1  sticky out-of-range-increment flag.

## Operation
- Accept handshake: `sum_valid && sum_ready`.
- Output handshake: `dout_valid && dout_ready`.
- FSM states:
  - PRIME: reset state. `prev` = 0. The first accepted sample produces `dout` = `sum_in`, loads `prev` = `sum_in`, and moves to RUN.
  - RUN: each accepted sample pushes `sum_in - prev` (WIDTH bits, carry discarded) into the output buffer and loads `prev` = `sum_in`.
- `resync` pulse:
  - Moves the FSM to PRIME and clears `prev` to 0 at the clock edge.
  - If an accept happens in the same cycle, that sample's delta is computed against the old `prev`; PRIME applies from the following sample.
- Output buffer:
  - 2 entries, FIFO order; `dout` is the head entry.
  - `sum_ready` = (count < 2), or count == 2 with an output pop in the same cycle.
  - `sum_ready` is 0 while `rst` is high.
- Wrap-around:
  - Subtraction is modulo 2^WIDTH; there is no overflow indication in the base build.
  - Example: `prev` = 0xFFF0, `sum_in` = 0x0005 gives 0x0015.
- Push and pop in the same cycle with count = 2: both occur and count stays 2.
- Reset values, applied at the first edge with `rst` high:
  - `dout` = 0, `dout_valid` = 0, `primed` = 0, `err_step` = 0.
  - Buffer emptied, `prev` = 0, state PRIME.
- Reset mid-operation discards buffered outputs; they are not delivered.

## Timing
- Latency is 1 cycle: a sample accepted at edge N appears on `dout` with `dout_valid` = 1 after edge N, when the buffer was empty.
- Throughput is 1 sample per cycle with `dout_ready` held high.
- Under a stall (`dout_ready` low), `sum_ready` stays high for exactly 2 more accepts, then drops in the same cycle count reaches 2.
- `dout` and `dout_valid` are stable while stalled.
- `primed` rises the cycle after the first accept in PRIME. It falls the cycle after `resync` or `rst`.
- `sum_ready` is combinational from count and `dout_ready`. No other output has a combinational input path.

## Configuration
- `FBDIFF_CLAMP_EN` defined:
  - The delta is interpreted as signed two's complement.
  - If |delta| > `MAX_STEP`, the buffer receives +`MAX_STEP` or -`MAX_STEP` (sign preserved) and `err_step` sets.
  - `err_step` clears only on `rst`.
  - The PRIME-state sample is exempt from the check.
- `FBDIFF_CLAMP_EN` undefined:
  - No clamp; raw modulo deltas are output.
  - `err_step` is tied 0.
  - `MAX_STEP` is unused.

## Test plan
- Reset, then push sums 20, 25, 29, 32 with `dout_ready` = 1 -> `dout` 20, 5, 4, 3, each one cycle after accept; `primed` = 1 from the cycle after the first accept.
- Wrap: prime with 0xFFF0, then push 0x0005 -> second `dout` = 0x0015.
- Backpressure: `dout_ready` = 0, push 10, 17, 30 -> only 10 and 17 accepted, `sum_ready` = 0. Release `dout_ready` -> `dout` 10 then 7, and 30 is accepted -> `dout` 13.
- `resync` after sums 20, 25, then push 8 -> `dout` = 8, not 0xFFEF. `resync` coincident with an accept of 40 (`prev` = 25) -> `dout` 15, and the next sample is primed.
- `rst` asserted with 2 entries buffered -> next cycle `dout_valid` = 0, `dout` = 0, `primed` = 0, `err_step` = 0. Push 9 -> `dout` = 9.
- With `FBDIFF_CLAMP_EN` and `MAX_STEP` = 255: sums 100, 1000 -> `dout` 100, 255, `err_step` = 1. Then sum 0 -> `dout` 0xFF01 (-255), and `err_step` stays 1 until `rst`.
